// File: rtl/immgen_pipe.sv
// Registered RISC-V immediate generator with a 2-entry skid buffer and valid/ready flow control.
// It forms I/S/B/U/J/Z immediates, flags illegal selects and carries a sideband tag.
module immgen_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [24:0]      in_instr,
   input  logic [2:0]       in_imm_sel,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic             out_err,
   output logic [TAG_W-1:0] out_tag,
   output logic [1:0]       dbg_state
);

   // Handshake: a transfer happens on a side only in a cycle where valid && ready are both high
   // at the rising edge; a presented output stays stable until it is taken.
   typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} state_e;

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic             err;
      logic [TAG_W-1:0] tag;
   } entry_t;

   state_e state_q, state_d;
   entry_t main_q, main_d;
   entry_t skid_q, skid_d;
   entry_t new_entry;
   logic   in_ready_q, in_ready_d;
   logic   acc, drain;

   logic [11:0] i_imm, s_imm;
   logic [12:0] b_imm;
   logic [31:0] u_imm;
   logic [20:0] j_imm;

   // in_instr[k-7] holds instruction bit k.
   assign i_imm = in_instr[24:13];
   assign s_imm = {in_instr[24:18], in_instr[4:0]};
   assign b_imm = {in_instr[24], in_instr[0], in_instr[23:18], in_instr[4:1], 1'b0};
   assign u_imm = {in_instr[24:5], 12'b0};
   assign j_imm = {in_instr[24], in_instr[12:5], in_instr[13], in_instr[23:14], 1'b0};

   always_comb begin
      new_entry     = '0;
      new_entry.tag = in_tag;
      case (in_imm_sel)
         3'd0:    new_entry.imm = XLEN'($signed(i_imm));
         3'd1:    new_entry.imm = XLEN'($signed(s_imm));
         3'd2:    new_entry.imm = XLEN'($signed(b_imm));
         3'd3:    new_entry.imm = XLEN'($signed(u_imm));
         3'd4:    new_entry.imm = XLEN'($signed(j_imm));
         3'd5:    new_entry.imm = XLEN'(in_instr[12:8]);
         default: new_entry.err = 1'b1;
      endcase
   end

   assign out_valid = (state_q != S_EMPTY);
   assign acc       = in_valid && in_ready_q && !flush;
   assign drain     = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         S_EMPTY: begin
            if (acc) begin
               main_d  = new_entry;
               state_d = S_ONE;
            end
         end
         S_ONE: begin
            if (acc && drain) begin
               main_d = new_entry;
            end else if (acc) begin
               skid_d  = new_entry;
               state_d = S_TWO;
            end else if (drain) begin
               state_d = S_EMPTY;
            end
         end
         S_TWO: begin
            if (drain) begin
               main_d  = skid_q;
               state_d = S_ONE;
            end
         end
         default: state_d = S_EMPTY;
      endcase
      if (flush) begin
         state_d = S_EMPTY;
      end
      in_ready_d = (state_d != S_TWO);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_imm   = main_q.imm;
   assign out_err   = main_q.err;
   assign out_tag   = main_q.tag;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_immgen_pipe.sv
// Bench for immgen_pipe: XLEN=32 and XLEN=64 instances share stimulus and are scored against a queue model.
module tb_immgen_pipe;

   localparam int TAG_W = 5;
   localparam int W     = 1 + TAG_W + 64;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic [24:0]      in_instr = '0;
   logic [2:0]       in_imm_sel = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_ready = 1'b0;

   logic             rdy32, vld32, err32, rdy64, vld64, err64;
   logic [31:0]      imm32;
   logic [63:0]      imm64;
   logic [TAG_W-1:0] tag32, tag64;
   logic [1:0]       st32, st64;

   int n_cmp = 0;
   int n_err = 0;
   logic [W-1:0] exp_q[$];

   always #5 clk = ~clk;

   immgen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
      .in_instr(in_instr), .in_imm_sel(in_imm_sel), .in_tag(in_tag), .out_valid(vld32),
      .out_ready(out_ready), .out_imm(imm32), .out_err(err32), .out_tag(tag32), .dbg_state(st32)
   );

   immgen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
      .in_instr(in_instr), .in_imm_sel(in_imm_sel), .in_tag(in_tag), .out_valid(vld64),
      .out_ready(out_ready), .out_imm(imm64), .out_err(err64), .out_tag(tag64), .dbg_state(st64)
   );

   // Reference immediate built from the full 32-bit word with signed shifts.
   function automatic logic [63:0] ref_imm(input logic [24:0] ii, input logic [2:0] sel);
      logic [31:0] w;
      longint s, r;
      w = {ii, 7'b0};
      s = longint'($signed(w));
      case (sel)
         3'd0: r = s >>> 20;
         3'd1: r = ((s >>> 25) << 5) | longint'(w[11:7]);
         3'd2: r = ((s >>> 31) << 12) | (longint'(w[7]) << 11) | (longint'(w[30:25]) << 5)
                   | (longint'(w[11:8]) << 1);
         3'd3: r = s & 64'hFFFF_FFFF_FFFF_F000;
         3'd4: r = ((s >>> 31) << 20) | (longint'(w[19:12]) << 12) | (longint'(w[20]) << 11)
                   | (longint'(w[30:21]) << 1);
         3'd5: r = longint'(w[19:15]);
         default: r = 0;
      endcase
      return 64'(r);
   endfunction

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // One clock: drive inputs, score outputs against the model head, advance the model.
   task automatic cyc(input logic v, input logic [31:0] instr, input logic [2:0] sel,
                      input logic [TAG_W-1:0] tag, input logic ordy, input logic fl);
      logic exp_rdy, exp_vld;
      logic [W-1:0] head;
      in_valid   = v;
      in_instr   = instr[31:7];
      in_imm_sel = sel;
      in_tag     = tag;
      out_ready  = ordy;
      flush      = fl;
      #1;
      exp_rdy = (exp_q.size() < 2);
      exp_vld = (exp_q.size() > 0);
      chk("in_ready32", 64'(rdy32), 64'(exp_rdy));
      chk("in_ready64", 64'(rdy64), 64'(exp_rdy));
      chk("out_valid32", 64'(vld32), 64'(exp_vld));
      chk("out_valid64", 64'(vld64), 64'(exp_vld));
      if (exp_vld) begin
         head = exp_q[0];
         chk("imm32", 64'(imm32), {32'b0, head[31:0]});
         chk("imm64", imm64, head[63:0]);
         chk("err32", 64'(err32), 64'(head[W-1]));
         chk("err64", 64'(err64), 64'(head[W-1]));
         chk("tag32", 64'(tag32), 64'(head[W-2:64]));
         chk("tag64", 64'(tag64), 64'(head[W-2:64]));
      end
      if (exp_vld && ordy) void'(exp_q.pop_front());
      if (fl) exp_q.delete();
      else if (v && exp_rdy) exp_q.push_back({sel > 3'd5, tag, ref_imm(instr[31:7], sel)});
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_valid", 64'(vld32), 64'd0);
      chk("rst_ready", 64'(rdy64), 64'd1);
      chk("rst_imm64", imm64, 64'd0);
      chk("rst_err", 64'(err32), 64'd0);
      chk("rst_tag", 64'(tag32), 64'd0);
      @(negedge clk);

      // Single I-type.
      cyc(1, 32'hFFF00093, 3'd0, 5'd3, 1, 0);
      chk("t1_imm32", 64'(imm32), 64'hFFFF_FFFF);
      chk("t1_tag", 64'(tag32), 64'd3);
      cyc(0, 0, 0, 0, 1, 0);

      // B then Z back to back, no bubble.
      cyc(1, 32'hFE000EE3, 3'd2, 5'd1, 1, 0);
      chk("t2_b_imm", 64'(imm32), 64'hFFFF_FFFC);
      cyc(1, 32'h3400D073, 3'd5, 5'd2, 1, 0);
      chk("t2_z_imm", 64'(imm32), 64'h1);
      chk("t2_ready", 64'(rdy32), 64'd1);
      cyc(0, 0, 0, 0, 1, 0);

      // Backpressure fills the skid.
      cyc(1, 32'h00102123, 3'd1, 5'd4, 0, 0);
      cyc(1, 32'h008000EF, 3'd4, 5'd5, 0, 0);
      chk("t3_full", 64'(rdy32), 64'd0);
      chk("t3_hold", 64'(imm32), 64'h2);
      cyc(1, 32'h00000093, 3'd0, 5'd6, 0, 0);
      chk("t3_hold2", 64'(imm32), 64'h2);
      cyc(0, 0, 0, 0, 1, 0);
      chk("t3_j_imm", 64'(imm32), 64'h8);
      chk("t3_ready", 64'(rdy32), 64'd1);
      cyc(0, 0, 0, 0, 1, 0);

      // U on XLEN=64, then illegal select.
      cyc(1, 32'h800000B7, 3'd3, 5'd7, 1, 0);
      chk("t4_u64", imm64, 64'hFFFF_FFFF_8000_0000);
      cyc(1, 32'h800000B7, 3'd7, 5'd8, 1, 0);
      chk("t4_ill_imm", imm64, 64'd0);
      chk("t4_ill_err", 64'(err64), 64'd1);
      cyc(0, 0, 0, 0, 1, 0);

      // Flush while full with a concurrent input.
      cyc(1, 32'h00100093, 3'd0, 5'd9, 0, 0);
      cyc(1, 32'h00200093, 3'd0, 5'd10, 0, 0);
      cyc(1, 32'h00300093, 3'd0, 5'd11, 0, 1);
      chk("t5_valid", 64'(vld32), 64'd0);
      chk("t5_ready", 64'(rdy32), 64'd1);
      cyc(0, 0, 0, 0, 1, 0);

      // Asynchronous reset mid-cycle while holding one entry.
      cyc(1, 32'hFFF00093, 3'd0, 5'd12, 0, 0);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_valid", 64'(vld64), 64'd0);
      chk("t6_imm", imm64, 64'd0);
      chk("t6_tag", 64'(tag64), 64'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1, 32'h7FF00093, 3'd0, 5'd13, 1, 0);
      chk("t6_first", 64'(imm32), 64'h7FF);
      cyc(0, 0, 0, 0, 1, 0);

      // Randomized traffic.
      for (int i = 0; i < 500; i++) begin
         cyc($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)), TAG_W'($urandom),
             $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
      end
      repeat (3) cyc(0, 0, 0, 0, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/immgen_pipe.md
Name: immgen_pipe

Overview:
- Registered, flow-controlled immediate generator for the RISC-V decode stage, parametrised in XLEN.
- Accepts instr[31:7] plus an immediate-type select and a sideband tag, and produces a sign/zero-extended XLEN immediate one cycle later.
- Valid/ready on both sides; an internal 2-entry skid buffer sustains full throughput with a registered in_ready.
- Adds CSR zimm (Z) type, illegal-select flagging and flush, none of which the combinational immgen has.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- TAG_W, 5, width of the sideband tag carried alongside each immediate (e.g. rd index).

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous; discards all buffered entries
- in_valid  input  1  upstream entry valid
- in_ready  output  1  block can accept; registered output
- in_instr  input  25  instruction bits [31:7]
- in_imm_sel  input  3  type select, shared imm_types encoding: I=0, S=1, B=2, U=3, J=4, Z=5; 6 and 7 are illegal
- in_tag  input  TAG_W  sideband, passed through unchanged
- out_valid  output  1  output entry valid
- out_ready  input  1  downstream accepts
- out_imm  output  XLEN  generated immediate
- out_err  output  1  entry had an illegal select
- out_tag  output  TAG_W  tag of the output entry

Behaviour:
- Handshakes:
  - Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
  - out_imm, out_err and out_tag are held stable while out_valid && !out_ready.
- Immediate formation (bit indices are instruction bits; in_instr[k-7] holds bit k):
  - I: {sext(b31), b30:20}
  - S: {sext(b31), b30:25, b11:7}
  - B: {sext(b31), b7, b30:25, b11:8, 0}
  - U: {sext(b31), b30:12, 12'b0}; on XLEN=64, bits 63:32 replicate b31.
  - J: {sext(b31), b19:12, b20, b30:21, 0}
  - Z: zero-extended b19:15
  - sel 6 or 7: out_imm = 0, out_err = 1. Otherwise out_err = 0.
- Storage: a main register (drives outputs) and a skid register.
- State machine:
  - EMPTY: in_ready=1, out_valid=0. Accept -> ONE.
  - ONE: in_ready=1, out_valid=1.
    - Accept with no drain -> TWO (new entry to skid).
    - Accept with drain -> ONE (new entry to main).
    - Drain only -> EMPTY.
  - TWO: in_ready=0, out_valid=1. Drain -> ONE (skid moves to main). in_valid ignored.
- Latency: an entry accepted in cycle N appears at the outputs in cycle N+1 at the earliest.
- Throughput: one entry per cycle with out_ready held high. Ordering is strictly FIFO.
- Flush:
  - Next state is EMPTY regardless of in_valid/out_ready that cycle.
  - An input presented in the flush cycle is dropped; in_ready may read 1 but no transfer takes effect.
  - A same-cycle output transfer still counts as consumed downstream.
- Reset (asynchronous assert, synchronous deassert via rst_n), state EMPTY:
  - out_valid=0, in_ready=1, out_imm=0, out_err=0, out_tag=0.
  - Reset mid-transfer discards all entries.
- in_ready depends only on state, never combinationally on out_ready.

Test Plan:
- Reset then single I-type: instr 0xFFF00093, sel 0, tag 3 -> one cycle later out_valid=1, out_imm=0xFFFFFFFF (XLEN=32), out_tag=3, out_err=0.
- B-type negative and Z type back-to-back, out_ready=1: 0xFE000EE3 sel 2 then 0x3400D073 sel 5 -> consecutive cycles give 0xFFFFFFFC then 0x00000001. No bubble; in_ready stays 1.
- Backpressure with out_ready=0: push S 0x00102123 then J 0x008000EF -> in_ready=0 after the second accept; outputs hold 0x00000002. Raise out_ready -> 0x00000002 then 0x00000008; in_ready returns to 1.
- XLEN=64, U-type 0x800000B7 sel 3 -> out_imm=0xFFFFFFFF80000000. Same run: sel 7 -> out_imm=0, out_err=1.
- Flush in state TWO, with in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1, and the flush-cycle input never appears at the output.
- rst_n pulsed low asynchronously mid-clock while in state ONE -> outputs zero immediately and out_valid=0; after release, the first accept behaves as from EMPTY.
